dsp_nco_sweep: RTL
==================

Name: dsp_nco_sweep

Overview:
- Linear frequency-sweep (chirp) controller that sits directly upstream of the NCO.
- Drives the NCO's frequency control word (phi_inc) and enable (en).
- Steps phi_inc from a start word toward a stop word in fixed increments, holding each frequency for a programmable number of cycles, then dwells at the stop word.
- Runs a single sweep or repeats continuously. Used for swept-tone stimulus and calibration.

Parameters:
- PHI_WIDTH, 32, width of frequency words; must equal the NCO's PHI_WIDTH.
- CNT_WIDTH, 16, width of the hold and dwell counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin a sweep; ignored while busy
- stop  in  1  abort; returns to idle on the next edge
- repeat_en  in  1  1 = restart from f_start after dwell; 0 = single sweep
- f_start  in  PHI_WIDTH  first frequency word (unsigned)
- f_stop  in  PHI_WIDTH  final frequency word (unsigned)
- f_step  in  PHI_WIDTH  increment per step (unsigned)
- hold_len  in  CNT_WIDTH  cycles each step frequency is held; 0 treated as 1
- dwell_len  in  CNT_WIDTH  cycles held at f_stop before end or restart; 0 = no dwell
- nco_en  out  1  connects to the NCO en
- phi_inc  out  PHI_WIDTH  connects to the NCO phi_inc
- busy  out  1  high in SWEEP or DWELL
- done  out  1  one-cycle pulse when a single sweep completes normally

Behaviour:
- Reset values: state IDLE, nco_en=0, phi_inc=0, busy=0, done=0, all counters 0. All outputs are registered.
- Configuration latching:
  - f_start, f_stop, f_step, hold_len, dwell_len and repeat_en are captured on the accepted start.
  - Input changes mid-sweep have no effect.
- IDLE:
  - start=1 and stop=0: phi_inc<=f_start, nco_en<=1, busy<=1, hold counter cleared.
  - If f_start>=f_stop, next state is DWELL with phi_inc<=f_stop. Otherwise next state is SWEEP.
- SWEEP:
  - Each frequency is held for max(hold_len,1) cycles.
  - At the end of a hold, compute nxt = phi_inc + f_step in PHI_WIDTH+1 bits.
  - If nxt >= f_stop (this includes carry out): phi_inc<=f_stop, go to DWELL.
  - Otherwise phi_inc<=nxt[PHI_WIDTH-1:0] and restart the hold.
  - f_step=0: phi_inc never advances and the sweep never ends; only stop exits. This is legal.
- DWELL:
  - Holds f_stop for dwell_len cycles. dwell_len=0 ends on the first DWELL cycle.
  - At the end, with latched repeat_en=1: phi_inc<=f_start, go to SWEEP (or DWELL again if f_start>=f_stop). nco_en stays 1 and no done pulse is issued.
  - At the end, with repeat_en=0: go to IDLE with phi_inc<=0, nco_en<=0, busy<=0, done<=1 for exactly one cycle.
- stop:
  - Highest priority, from any state.
  - Next edge: IDLE, nco_en=0, phi_inc=0, busy=0, done=0.
  - start and stop in the same cycle: stop wins, no sweep begins.
- Latency: phi_inc is valid on the same edge that nco_en rises. The NCO accumulator clears while en=0, so every sweep begins at phase 0.
- Reset mid-sweep: immediate return to reset values. No done pulse.

Optional Feature:
- Macro: DSP_NCO_SWEEP_DOWN_EN.
- Defined:
  - When f_start > f_stop, the sweep runs downward: nxt = phi_inc - f_step, with borrow or nxt <= f_stop clamping to f_stop and entering DWELL.
  - f_start == f_stop goes straight to DWELL.
- Undefined:
  - Upward only; f_start >= f_stop goes straight to DWELL at f_stop.
  - No subtractor is built.

Decomposition:
- Shared package dsp_nco_pkg holds:
  - the state encoding enum (S_IDLE, S_SWEEP, S_DWELL);
  - the default PHI_WIDTH localparam shared with the NCO.
- One natural sub-module: dsp_nco_sweep_cnt, a loadable down-counter with a terminal-count flag, instantiated for both hold and dwell timing.

Test Plan:
- f_start=100, f_stop=400, f_step=100, hold_len=2, dwell_len=3, repeat_en=0, start pulse:
  - phi_inc sequence 100,100,200,200,300,300,400,400,400.
  - Then done=1 for one cycle, nco_en=0, phi_inc=0.
- Overshoot clamp: f_start=0, f_stop=250, f_step=100, hold_len=1:
  - phi_inc 0,100,200,250, then dwell.
  - The value 300 never appears.
- Overflow clamp: f_start=32'hFFFF_FF00, f_stop=32'hFFFF_FFFF, f_step=32'h200:
  - Carry detected, phi_inc jumps to 32'hFFFF_FFFF.
  - No wrap to a small value.
- Repeat mode with dwell_len=0:
  - After reaching f_stop, the next cycle shows f_start.
  - busy and nco_en stay high, done never pulses over 3 periods.
- stop asserted mid-SWEEP, and start+stop together in IDLE:
  - Next edge shows nco_en=0, phi_inc=0, busy=0, done=0.
  - The simultaneous case never raises busy.
- rst_n dropped asynchronously mid-DWELL:
  - Outputs go to reset values without waiting for a clock edge.
  - A start after release begins a fresh sweep.

Source files
------------

// File: rtl/dsp_nco_pkg.sv
// Shared definitions for the NCO and its sweep controller: state encoding and
// the default frequency-word width that the NCO also uses.
package dsp_nco_pkg;

  localparam int unsigned PHI_WIDTH_DEF = 32;
  localparam int unsigned CNT_WIDTH_DEF = 16;

  // Sweep controller states
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SWEEP = 2'd1;
  localparam state_t S_DWELL = 2'd2;

endpackage

// File: rtl/dsp_nco_sweep_if.sv
// Control/config bus of the sweep controller. The master side issues start/stop
// and the sweep configuration; the slave side (the controller) returns the NCO
// drive and status.
interface dsp_nco_sweep_if
  import dsp_nco_pkg::*;
#(
  parameter int unsigned PHI_WIDTH = PHI_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
);
  logic                 start;
  logic                 stop;
  logic                 repeat_en;
  logic [PHI_WIDTH-1:0] f_start;
  logic [PHI_WIDTH-1:0] f_stop;
  logic [PHI_WIDTH-1:0] f_step;
  logic [CNT_WIDTH-1:0] hold_len;
  logic [CNT_WIDTH-1:0] dwell_len;
  logic                 nco_en;
  logic [PHI_WIDTH-1:0] phi_inc;
  logic                 busy;
  logic                 done;

  modport master (
    output start, stop, repeat_en, f_start, f_stop, f_step, hold_len, dwell_len,
    input  nco_en, phi_inc, busy, done
  );

  modport slave (
    input  start, stop, repeat_en, f_start, f_stop, f_step, hold_len, dwell_len,
    output nco_en, phi_inc, busy, done
  );
endinterface

// File: rtl/dsp_nco_sweep_cnt.sv
// Loadable down-counter with terminal-count flag. It stops at zero; tc is high
// while the count is zero, so loading N gives N+1 cycles until tc.
module dsp_nco_sweep_cnt #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 tc
);
  localparam logic [CNT_WIDTH-1:0] CntOne = 1;

  logic [CNT_WIDTH-1:0] cnt_q;

  // Clear has priority over load; otherwise count down to zero and stay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntOne;
    end
  end

  assign tc = (cnt_q == '0);
endmodule

// File: rtl/dsp_nco_sweep.sv
// Linear frequency-sweep (chirp) controller driving the NCO phi_inc/en.
// Optional build macro DSP_NCO_SWEEP_DOWN_EN: when defined, f_start > f_stop
// sweeps downward; when undefined only upward sweeps exist and no subtractor
// is built. PHI_WIDTH must match the width of the bus interface instance.
module dsp_nco_sweep
  import dsp_nco_pkg::*;
#(
  parameter int unsigned PHI_WIDTH = PHI_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input logic             clk,
  input logic             rst_n,
  dsp_nco_sweep_if.slave  bus
);
  localparam logic [CNT_WIDTH-1:0] CntOne = 1;

  state_t               state_q, state_d;
  logic [PHI_WIDTH-1:0] phi_q, phi_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Configuration captured on the accepted start
  logic [PHI_WIDTH-1:0] start_q, stop_q, step_q;
  logic [CNT_WIDTH-1:0] hold_q, dwell_q;
  logic                 rep_q;
  logic                 cfg_load;

  logic                 hold_load, dwell_load, cnt_clr;
  logic                 hold_tc, dwell_tc;
  logic [CNT_WIDTH-1:0] hold_val, dwell_val;

  // In IDLE the entry values come straight from the bus, otherwise from the latch
  logic [PHI_WIDTH-1:0] src_start, src_stop;
  logic [CNT_WIDTH-1:0] src_hold, src_dwell;

  logic [PHI_WIDTH:0]   nxt_up;
  logic                 clamp;

`ifdef DSP_NCO_SWEEP_DOWN_EN
  logic                 dir_q, dir_d;
  logic [PHI_WIDTH:0]   nxt_dn;
`endif

  // True when a sweep entered from (fs, fp) skips SWEEP and sits at f_stop
  function automatic logic direct_dwell(input logic [PHI_WIDTH-1:0] fs,
                                        input logic [PHI_WIDTH-1:0] fp);
`ifdef DSP_NCO_SWEEP_DOWN_EN
    return fs == fp;
`else
    return fs >= fp;
`endif
  endfunction

  // Select config source and compute next step with clamp decision
  always_comb begin
    src_start = (state_q == S_IDLE) ? bus.f_start   : start_q;
    src_stop  = (state_q == S_IDLE) ? bus.f_stop    : stop_q;
    src_hold  = (state_q == S_IDLE) ? bus.hold_len  : hold_q;
    src_dwell = (state_q == S_IDLE) ? bus.dwell_len : dwell_q;
    // A length of N means the counter is loaded with N-1; 0 behaves like 1
    hold_val  = (src_hold  == '0) ? '0 : src_hold  - CntOne;
    dwell_val = (src_dwell == '0) ? '0 : src_dwell - CntOne;
    // Extra bit keeps the carry so overflow clamps instead of wrapping
    nxt_up    = {1'b0, phi_q} + {1'b0, step_q};
`ifdef DSP_NCO_SWEEP_DOWN_EN
    nxt_dn    = {1'b0, phi_q} - {1'b0, step_q};
    if (dir_q) begin
      clamp = nxt_dn[PHI_WIDTH] || (nxt_dn[PHI_WIDTH-1:0] <= stop_q);
    end else begin
      clamp = nxt_up >= {1'b0, stop_q};
    end
`else
    clamp     = nxt_up >= {1'b0, stop_q};
`endif
  end

  // Next-state logic; stop overrides everything
  always_comb begin
    state_d    = state_q;
    phi_d      = phi_q;
    en_d       = en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cfg_load   = 1'b0;
    hold_load  = 1'b0;
    dwell_load = 1'b0;
    cnt_clr    = 1'b0;
`ifdef DSP_NCO_SWEEP_DOWN_EN
    dir_d      = dir_q;
`endif
    if (bus.stop) begin
      state_d = S_IDLE;
      phi_d   = '0;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE, S_DWELL: begin
          if ((state_q == S_IDLE && bus.start) ||
              (state_q == S_DWELL && dwell_tc && rep_q)) begin
            cfg_load = (state_q == S_IDLE);
            en_d     = 1'b1;
            busy_d   = 1'b1;
`ifdef DSP_NCO_SWEEP_DOWN_EN
            dir_d    = src_start > src_stop;
`endif
            if (direct_dwell(src_start, src_stop)) begin
              state_d    = S_DWELL;
              phi_d      = src_stop;
              dwell_load = 1'b1;
            end else begin
              state_d   = S_SWEEP;
              phi_d     = src_start;
              hold_load = 1'b1;
            end
          end else if (state_q == S_DWELL && dwell_tc) begin
            state_d = S_IDLE;
            phi_d   = '0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        S_SWEEP: begin
          if (hold_tc) begin
            if (clamp) begin
              state_d    = S_DWELL;
              phi_d      = stop_q;
              dwell_load = 1'b1;
            end else begin
`ifdef DSP_NCO_SWEEP_DOWN_EN
              phi_d = dir_q ? nxt_dn[PHI_WIDTH-1:0] : nxt_up[PHI_WIDTH-1:0];
`else
              phi_d = nxt_up[PHI_WIDTH-1:0];
`endif
              hold_load = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          phi_d   = '0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phi_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phi_q   <= phi_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Configuration latch, written only when a start is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      dwell_q <= '0;
      rep_q   <= 1'b0;
    end else if (cfg_load) begin
      start_q <= bus.f_start;
      stop_q  <= bus.f_stop;
      step_q  <= bus.f_step;
      hold_q  <= bus.hold_len;
      dwell_q <= bus.dwell_len;
      rep_q   <= bus.repeat_en;
    end
  end

`ifdef DSP_NCO_SWEEP_DOWN_EN
  // Sweep direction, decided on every entry into a sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= 1'b0;
    else        dir_q <= dir_d;
  end
`endif

  dsp_nco_sweep_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_hold_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (hold_load),
    .load_val (hold_val),
    .tc       (hold_tc)
  );

  dsp_nco_sweep_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_dwell_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (dwell_load),
    .load_val (dwell_val),
    .tc       (dwell_tc)
  );

  assign bus.nco_en  = en_q;
  assign bus.phi_inc = phi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
